// File: rtl/key_mode_counter.sv
// key_mode_counter: captures the key-selected mode on each key pulse and
// runs a two-digit BCD counter (00-99) stepped by a prescaled tick.
module key_mode_counter #(
   parameter logic [25:0] CNT_MAX = 26'd49_999_999
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [1:0] key_select,
   input  logic       key_en,
   output logic [7:0] cnt_bcd,
   output logic [1:0] state,
   output logic [3:0] led,
   output logic       tick,
   output logic       wrap
);

   localparam logic [1:0] S_STOP  = 2'd0;
   localparam logic [1:0] S_UP    = 2'd1;
   localparam logic [1:0] S_DOWN  = 2'd2;
   localparam logic [1:0] S_CLEAR = 2'd3;

   logic [1:0]  state_next;
   logic [3:0]  led_next;
   logic [25:0] psc;
   logic [25:0] psc_next;
   logic        step;
   logic [7:0]  cnt_inc;
   logic [7:0]  cnt_dec;
   logic [7:0]  cnt_next;
   logic        wrap_next;

   // State register, with the one-hot LED image registered alongside it
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= S_STOP;
         led   <= 4'b0001;
      end else begin
         state <= state_next;
         led   <= led_next;
      end
   end

   // Next mode: a key pulse always wins, CLEAR lasts a single cycle
   always_comb begin
      state_next = state;
      if (key_en) begin
         state_next = key_select;
      end else if (state == S_CLEAR) begin
         state_next = S_STOP;
      end
   end

   // LED image of the mode that will be current next cycle
   always_comb begin
      led_next = 4'b0001;
      unique case (state_next)
         S_STOP:  led_next = 4'b0001;
         S_UP:    led_next = 4'b0010;
         S_DOWN:  led_next = 4'b0100;
         S_CLEAR: led_next = 4'b1000;
         default: led_next = 4'b0001;
      endcase
   end

   // Prescaler; a key pulse restarts it and swallows a coincident terminal count
   always_comb begin
      step     = 1'b0;
      psc_next = '0;
      if (!key_en && (state == S_UP || state == S_DOWN)) begin
         if (psc == CNT_MAX) begin
            step = 1'b1;
         end else begin
            psc_next = psc + 26'd1;
         end
      end
   end

   // BCD increment and decrement of the current count
   always_comb begin
      cnt_inc = cnt_bcd;
      cnt_dec = cnt_bcd;
      if (cnt_bcd[3:0] == 4'd9) begin
         cnt_inc[3:0] = 4'd0;
         cnt_inc[7:4] = (cnt_bcd[7:4] == 4'd9) ? 4'd0 : cnt_bcd[7:4] + 4'd1;
      end else begin
         cnt_inc[3:0] = cnt_bcd[3:0] + 4'd1;
      end
      if (cnt_bcd[3:0] == 4'd0) begin
         cnt_dec[3:0] = 4'd9;
         cnt_dec[7:4] = (cnt_bcd[7:4] == 4'd0) ? 4'd9 : cnt_bcd[7:4] - 4'd1;
      end else begin
         cnt_dec[3:0] = cnt_bcd[3:0] - 4'd1;
      end
   end

   // Count selection and wrap detection for this edge
   always_comb begin
      cnt_next  = cnt_bcd;
      wrap_next = 1'b0;
      if (key_en && key_select == S_CLEAR) begin
         cnt_next = 8'h00;
      end else if (step && state == S_UP) begin
         cnt_next  = cnt_inc;
         wrap_next = (cnt_bcd == 8'h99);
      end else if (step && state == S_DOWN) begin
         cnt_next  = cnt_dec;
         wrap_next = (cnt_bcd == 8'h00);
      end
   end

   // Datapath registers: prescaler, count and event pulses
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         psc     <= '0;
         cnt_bcd <= 8'h00;
         tick    <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         psc     <= psc_next;
         cnt_bcd <= cnt_next;
         tick    <= step;
         wrap    <= wrap_next;
      end
   end

endmodule

// File: tb/tb_key_mode_counter.sv
// Bench for key_mode_counter: directed vector table, corner-case sequences
// and random stimulus checked against an integer reference model.
module tb_key_mode_counter;

   localparam int CM = 4;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [1:0] key_select;
   logic       key_en;
   logic [7:0] cnt_bcd;
   logic [1:0] state;
   logic [3:0] led;
   logic       tick;
   logic       wrap;

   int n_checks = 0;
   int n_fail   = 0;

   int m_state = 0;
   int m_psc   = 0;
   int m_cnt   = 0;
   bit m_tick  = 1'b0;
   bit m_wrap  = 1'b0;

   typedef struct {
      bit         rst;
      bit         en;
      logic [1:0] sel;
      logic [7:0] cnt;
      logic [1:0] st;
      bit         tk;
   } vec_t;

   vec_t tbl[$];

   key_mode_counter #(.CNT_MAX(26'd4)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key_select (key_select),
      .key_en     (key_en),
      .cnt_bcd    (cnt_bcd),
      .state      (state),
      .led        (led),
      .tick       (tick),
      .wrap       (wrap)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [7:0] to_bcd(int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: whole-number count, mode and phase within the period
   task automatic model_edge(bit rst, bit en, int sel);
      if (rst) begin
         m_state = 0; m_psc = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
      end else begin
         m_tick = 0;
         m_wrap = 0;
         if (en) begin
            m_state = sel;
            m_psc   = 0;
            if (sel == 3) m_cnt = 0;
         end else if (m_state == 3) begin
            m_state = 0;
         end else if (m_state == 1 || m_state == 2) begin
            if (m_psc == CM) begin
               m_psc  = 0;
               m_tick = 1;
               if (m_state == 1) begin
                  m_wrap = (m_cnt == 99);
                  m_cnt  = (m_cnt + 1) % 100;
               end else begin
                  m_wrap = (m_cnt == 0);
                  m_cnt  = (m_cnt + 99) % 100;
               end
            end else begin
               m_psc++;
            end
         end
      end
   endtask

   task automatic cycle(bit rst, bit en, logic [1:0] sel);
      sys_rst    = rst;
      key_en     = en;
      key_select = sel;
      @(posedge sys_clk);
      model_edge(rst, en, int'(sel));
      #1;
      check("model", 32'({cnt_bcd, state, led, tick, wrap}),
            32'({to_bcd(m_cnt), 2'(m_state), 4'(1 << m_state), m_tick, m_wrap}));
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 2'd0);
   endtask

   // Idle until the DUT raises tick; returns edges taken (0 on timeout)
   task automatic wait_tick(output int k);
      k = 0;
      for (int i = 1; i <= 4 * (CM + 1); i++) begin
         idle();
         if (tick === 1'b1) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic push(bit rst, bit en, logic [1:0] sel,
                       logic [7:0] cnt, logic [1:0] st, bit tk);
      vec_t v;
      v.rst = rst; v.en = en; v.sel = sel;
      v.cnt = cnt; v.st = st; v.tk = tk;
      tbl.push_back(v);
   endtask

   initial begin
      int k;
      int c;
      bit r;
      bit e;

      sys_rst    = 1'b1;
      key_en     = 1'b0;
      key_select = 2'd0;

      for (int i = 0; i < 3; i++) push(1, 1, 2'd1, 8'h00, 2'd0, 0);
      push(0, 1, 2'd1, 8'h00, 2'd1, 0);
      for (int s = 1; s <= 3; s++) begin
         for (int i = 0; i < 4; i++) push(0, 0, 2'd0, 8'(s - 1), 2'd1, 0);
         push(0, 0, 2'd0, 8'(s), 2'd1, 1);
      end

      foreach (tbl[i]) begin
         cycle(tbl[i].rst, tbl[i].en, tbl[i].sel);
         check("table", 32'({cnt_bcd, state, led, tick}),
               32'({tbl[i].cnt, tbl[i].st, 4'(1 << tbl[i].st), tbl[i].tk}));
      end

      for (int i = 0; i < 200 && m_cnt != 9; i++) idle();
      check("reach_09", 32'(cnt_bcd), 32'h09);
      wait_tick(k);
      check("bcd_carry", 32'(cnt_bcd), 32'h10);

      for (int i = 0; i < 1000 && m_cnt != 99; i++) idle();
      wait_tick(k);
      check("wrap_up", 32'({cnt_bcd, tick, wrap}), 32'({8'h00, 1'b1, 1'b1}));

      cycle(1'b0, 1'b1, 2'd2);
      wait_tick(k);
      check("wrap_down", 32'({cnt_bcd, wrap}), 32'({8'h99, 1'b1}));
      check("down_first_step", 32'(k), 32'(CM + 1));
      for (int i = 0; i < 1000 && m_cnt != 10; i++) idle();
      wait_tick(k);
      check("bcd_borrow", 32'({cnt_bcd, wrap}), 32'({8'h09, 1'b0}));

      cycle(1'b0, 1'b1, 2'd1);
      for (int i = 0; i < 10 && m_psc != CM; i++) idle();
      c = m_cnt;
      cycle(1'b0, 1'b1, 2'd2);
      check("collision", 32'({cnt_bcd, state, tick}),
            32'({to_bcd(c), 2'd2, 1'b0}));
      wait_tick(k);
      check("collision_delay", 32'(k), 32'(CM + 1));

      cycle(1'b0, 1'b1, 2'd1);
      for (int i = 0; i < 1000 && m_cnt != 37; i++) idle();
      check("reach_37", 32'(cnt_bcd), 32'h37);
      cycle(1'b0, 1'b1, 2'd3);
      check("clear", 32'({cnt_bcd, state, led, tick}),
            32'({8'h00, 2'd3, 4'b1000, 1'b0}));
      idle();
      check("clear_to_stop", 32'({state, led, tick}), 32'({2'd0, 4'b0001, 1'b0}));
      for (int i = 0; i < 20; i++) idle();
      check("clear_hold", 32'({cnt_bcd, state}), 32'({8'h00, 2'd0}));

      cycle(1'b0, 1'b1, 2'd3);
      cycle(1'b0, 1'b1, 2'd1);
      check("clear_then_key", 32'({state, led}), 32'({2'd1, 4'b0010}));

      for (int i = 0; i < 10 && m_psc != 3; i++) idle();
      c = m_cnt;
      cycle(1'b0, 1'b1, 2'd1);
      check("repress_keep", 32'({cnt_bcd, state}), 32'({to_bcd(c), 2'd1}));
      wait_tick(k);
      check("repress_delay", 32'(k), 32'(CM + 1));
      check("repress_step", 32'(cnt_bcd), 32'(to_bcd((c + 1) % 100)));

      for (int i = 0; i < 6; i++) idle();
      cycle(1'b1, 1'b0, 2'd0);
      check("reset_mid", 32'({cnt_bcd, state, tick, wrap}), 32'h0);

      for (int i = 0; i < 4000; i++) begin
         r = ($urandom_range(0, 299) == 0);
         e = ($urandom_range(0, 11) == 0);
         cycle(r, e, 2'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
